// File: rtl/intersection_ctrl.sv
// -----------------------------------------------------------------------------
// intersection_ctrl
//
// Two-road intersection scheduler. The main road rests in green; a latched
// side-road vehicle request (and, when built with the pedestrian option, a
// latched pedestrian request) starts a fixed cycle:
//   main yellow -> all red -> side green -> side yellow -> all red
//   -> [walk] -> main green
// With only a pedestrian request pending, the cycle goes from the first
// all-red straight to walk and then back to main green.
//
// Build option:
//   INTERSECTION_CTRL_PED_WALK_EN  defined   : walk phase, ped_pending latch
//                                              and walk lamp are present.
//                                  undefined : ped_req is ignored, walk is 0,
//                                              and the all-red states always
//                                              go to side green / main green.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   side_req     in   side-road vehicle sensor (level)
//   ped_req      in   pedestrian button (pulse or level)
//   main_green   out  main-road head, green lamp
//   main_yellow  out  main-road head, yellow lamp
//   main_red     out  main-road head, red lamp
//   side_green   out  side-road head, green lamp
//   side_yellow  out  side-road head, yellow lamp
//   side_red     out  side-road head, red lamp
//   walk         out  pedestrian walk lamp
//   phase        out  current state code (also serves as the FSM debug view)
//                     0 MAIN_GREEN, 1 MAIN_YELLOW, 2 ALL_RED_A,
//                     3 SIDE_GREEN, 4 SIDE_YELLOW, 5 ALL_RED_B, 6 WALK
//
// All lamps are registered and are a pure decode of the state register:
// they are loaded from the decode of the next state on the same edge that
// loads the state, so lamps and phase always agree.
// -----------------------------------------------------------------------------
module intersection_ctrl #(
  parameter int CNT_W          = 8,
  parameter int MAIN_GREEN_MIN = 8,
  parameter int SIDE_GREEN     = 6,
  parameter int YELLOW         = 3,
  parameter int ALL_RED        = 2,
  parameter int WALK           = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic       main_green,
  output logic       main_yellow,
  output logic       main_red,
  output logic       side_green,
  output logic       side_yellow,
  output logic       side_red,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_ALL_RED_B   = 3'd5,
    ST_WALK        = 3'd6,
    ST_ILLEGAL     = 3'd7
  } state_t;

  // Last timer value of each timed state: a state with dwell N is left on
  // the edge where tmr == N-1, so it is occupied for exactly N cycles.
  localparam logic [CNT_W-1:0] MG_LAST = CNT_W'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SG_LAST = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALL_RED - 1);

  // Lamp vector order: {main_green, main_yellow, main_red,
  //                     side_green, side_yellow, side_red, walk}
  function automatic logic [6:0] lamps_of(input state_t s);
    logic [6:0] l;
    case (s)
      ST_MAIN_GREEN:  l = 7'b100_001_0;
      ST_MAIN_YELLOW: l = 7'b010_001_0;
      ST_ALL_RED_A:   l = 7'b001_001_0;
      ST_SIDE_GREEN:  l = 7'b001_100_0;
      ST_SIDE_YELLOW: l = 7'b001_010_0;
      ST_ALL_RED_B:   l = 7'b001_001_0;
`ifdef INTERSECTION_CTRL_PED_WALK_EN
      ST_WALK:        l = 7'b001_001_1;
`endif
      // Anything unexpected shows all red, which is the safe display.
      default:        l = 7'b001_001_0;
    endcase
    return l;
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W-1:0] tmr_nxt;
  logic             side_pending;
  logic             side_pending_nxt;
  logic             ped_pend;       // ped_pending, or constant 0 when absent

`ifdef INTERSECTION_CTRL_PED_WALK_EN
  logic             ped_pending;
  logic             ped_pending_nxt;
  assign ped_pend = ped_pending;
`else
  assign ped_pend = 1'b0;
  // Pedestrian input and walk dwell have no function in this build.
  logic unused_ped;
  assign unused_ped = ped_req & (WALK != 0);
`endif

  assign phase = state;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_MAIN_GREEN: begin
        // Uses the registered pendings: a request latched on edge k can
        // cause the exit no earlier than edge k+1.
        if (tmr == MG_LAST && (side_pending || ped_pend))
          state_nxt = ST_MAIN_YELLOW;
      end
      ST_MAIN_YELLOW: begin
        if (tmr == Y_LAST) state_nxt = ST_ALL_RED_A;
      end
      ST_ALL_RED_A: begin
        if (tmr == AR_LAST) begin
`ifdef INTERSECTION_CTRL_PED_WALK_EN
          // Only a pedestrian request can have brought us here without a
          // side request, so skip side service and go straight to walk.
          state_nxt = side_pending ? ST_SIDE_GREEN : ST_WALK;
`else
          state_nxt = ST_SIDE_GREEN;
`endif
        end
      end
      ST_SIDE_GREEN: begin
        if (tmr == SG_LAST) state_nxt = ST_SIDE_YELLOW;
      end
      ST_SIDE_YELLOW: begin
        if (tmr == Y_LAST) state_nxt = ST_ALL_RED_B;
      end
      ST_ALL_RED_B: begin
        if (tmr == AR_LAST) begin
`ifdef INTERSECTION_CTRL_PED_WALK_EN
          state_nxt = ped_pend ? ST_WALK : ST_MAIN_GREEN;
`else
          state_nxt = ST_MAIN_GREEN;
`endif
        end
      end
`ifdef INTERSECTION_CTRL_PED_WALK_EN
      ST_WALK: begin
        if (tmr == CNT_W'(WALK - 1)) state_nxt = ST_MAIN_GREEN;
      end
`endif
      // Code 7, and code 6 when walk is not built, recover to main green.
      default: state_nxt = ST_MAIN_GREEN;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dwell timer and request latches
  // ---------------------------------------------------------------------------
  always_comb begin
    tmr_nxt = tmr + CNT_W'(1);
    if (state_nxt != state)
      tmr_nxt = '0;
    else if (state == ST_MAIN_GREEN && tmr == MG_LAST)
      // Main green may rest forever; the timer parks at its last value so
      // that a late request exits one edge after it is latched.
      tmr_nxt = tmr;
  end

  always_comb begin
    side_pending_nxt = side_pending;
    // Clearing on entry to side green wins over a request on that edge.
    if (state_nxt == ST_SIDE_GREEN && state != ST_SIDE_GREEN)
      side_pending_nxt = 1'b0;
    else if (side_req && state != ST_SIDE_GREEN)
      side_pending_nxt = 1'b1;
  end

`ifdef INTERSECTION_CTRL_PED_WALK_EN
  always_comb begin
    ped_pending_nxt = ped_pending;
    if (state_nxt == ST_WALK && state != ST_WALK)
      ped_pending_nxt = 1'b0;
    else if (ped_req && state != ST_WALK)
      ped_pending_nxt = 1'b1;
  end
`endif

  // ---------------------------------------------------------------------------
  // State, timer, pendings and registered lamps
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset jumps straight to main green, no yellow is inserted.
      state        <= ST_MAIN_GREEN;
      tmr          <= '0;
      side_pending <= 1'b0;
`ifdef INTERSECTION_CTRL_PED_WALK_EN
      ped_pending  <= 1'b0;
`endif
      {main_green, main_yellow, main_red,
       side_green, side_yellow, side_red, walk} <= lamps_of(ST_MAIN_GREEN);
    end else begin
      state        <= state_nxt;
      tmr          <= tmr_nxt;
      side_pending <= side_pending_nxt;
`ifdef INTERSECTION_CTRL_PED_WALK_EN
      ped_pending  <= ped_pending_nxt;
`endif
      {main_green, main_yellow, main_red,
       side_green, side_yellow, side_red, walk} <= lamps_of(state_nxt);
    end
  end

endmodule
